// File: rtl/ir_pkg.sv
// Shared types and constants for the IR key queue.
// Provides key width, key type and the default repeat holdoff.
package ir_pkg;

  localparam int KEY_W = 4;

  typedef logic [KEY_W-1:0] key_t;

  localparam int HOLDOFF_DEF = 1_000_000;

  localparam key_t KEY_RST = '1;

endpackage

// File: rtl/key_fifo.sv
// Circular key store with registered occupancy count.
// Ports: clk, rst, pushReq/wrData, popReq, rdData, count, nextCount, pushDrop.
module key_fifo
  import ir_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pushReq,
  input  key_t          wrData,
  input  logic          popReq,
  output key_t          rdData,
  output logic [CW-1:0] count,
  output logic [CW-1:0] nextCount,
  output logic          pushDrop
);

  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  key_t mem [DEPTH];

  logic [PW-1:0] wrPtr;
  logic [PW-1:0] rdPtr;
  logic          empty;
  logic          doPop;
  logic          doPush;

  assign empty = (count == '0);

  // A pop on a full queue frees the slot the same cycle.
  assign doPop    = popReq && !empty;
  assign doPush   = pushReq && ((count < FULL) || doPop);
  assign pushDrop = pushReq && !doPush;

  always_comb begin
    nextCount = count;
    unique case ({doPush, doPop})
      2'b10:   nextCount = count + CW'(1);
      2'b01:   nextCount = count - CW'(1);
      default: nextCount = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      count <= nextCount;
      if (doPush)
        wrPtr <= wrPtr + PW'(1);
      if (doPop)
        rdPtr <= rdPtr + PW'(1);
    end
  end

  // Storage is not cleared; stale entries sit behind the pointers.
  always_ff @(posedge clk) begin
    if (!rst && doPush)
      mem[wrPtr] <= wrData;
  end

  assign rdData = empty ? '0 : mem[rdPtr];

endmodule

// File: rtl/ir_key_queue.sv
// IR key queue: repeat filter, FIFO, sticky overflow and irq.
// Ports: key_valid/key_code in, irq/irq_ack, key_data, count, overflow/overflow_clr.
module ir_key_queue
  import ir_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int HOLDOFF = HOLDOFF_DEF,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          key_valid,
  input  key_t          key_code,
  output logic          irq,
  input  logic          irq_ack,
  output key_t          key_data,
  output logic [CW-1:0] count,
  output logic          overflow,
  input  logic          overflow_clr
);

  localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam logic [HW-1:0] RELOAD = HW'(HOLDOFF - 1);

  key_t          lastCode;
  logic [HW-1:0] holdoff;
  logic          suppress;
  logic          pushReq;
  logic          pushDrop;
  logic [CW-1:0] nextCount;

  // Same key inside the holdoff window is an auto-repeat.
  assign suppress = key_valid
                 && (key_code == lastCode)
                 && (holdoff != '0);
  assign pushReq  = key_valid && !suppress;

  key_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .pushReq  (pushReq),
    .wrData   (key_code),
    .popReq   (irq_ack),
    .rdData   (key_data),
    .count    (count),
    .nextCount(nextCount),
    .pushDrop (pushDrop)
  );

  // Any key, kept or dropped, restarts the window.
  always_ff @(posedge clk) begin
    if (rst) begin
      lastCode <= KEY_RST;
      holdoff  <= '0;
    end else if (key_valid) begin
      lastCode <= key_code;
      holdoff  <= RELOAD;
    end else if (holdoff != '0) begin
      holdoff  <= holdoff - HW'(1);
    end
  end

  // A fresh loss beats a clear in the same cycle.
  always_ff @(posedge clk) begin
    if (rst)
      overflow <= 1'b0;
    else if (pushDrop)
      overflow <= 1'b1;
    else if (overflow_clr)
      overflow <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst)
      irq <= 1'b0;
    else
      irq <= (nextCount != '0);
  end

endmodule

// File: tb/tb_ir_key_queue.sv
// Directed self-checking bench for ir_key_queue.
// Table vectors plus multi-cycle fill, repeat and overflow sequences.
module tb_ir_key_queue;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_valid;
  logic [3:0] key_code;
  logic       irq;
  logic       irq_ack;
  logic [3:0] key_data;
  logic [3:0] count;
  logic       overflow;
  logic       overflow_clr;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ir_key_queue #(
    .DEPTH  (8),
    .HOLDOFF(10)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .irq         (irq),
    .irq_ack     (irq_ack),
    .key_data    (key_data),
    .count       (count),
    .overflow    (overflow),
    .overflow_clr(overflow_clr)
  );

  typedef struct {
    logic       r;
    logic       kv;
    logic [3:0] code;
    logic       ack;
    logic       clr;
    logic       eIrq;
    logic [3:0] eData;
    logic [3:0] eCnt;
    logic       eOvf;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs; outputs sampled 1ns after the edge.
  task automatic cyc(input logic r, input logic kv, input logic [3:0] c,
                     input logic a, input logic cl);
    rst          = r;
    key_valid    = kv;
    key_code     = c;
    irq_ack      = a;
    overflow_clr = cl;
    @(posedge clk);
    #1;
    rst          = 1'b0;
    key_valid    = 1'b0;
    key_code     = 4'h0;
    irq_ack      = 1'b0;
    overflow_clr = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      cyc(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
  endtask

  task automatic chk4(input string tag, input logic eIrq, input int eData,
                      input int eCnt, input logic eOvf);
    check({tag, ".irq"}, int'(irq), int'(eIrq));
    check({tag, ".data"}, int'(key_data), eData);
    check({tag, ".count"}, int'(count), eCnt);
    check({tag, ".ovf"}, int'(overflow), int'(eOvf));
  endtask

  function automatic vec_t mk(input logic r, input logic kv,
                              input logic [3:0] c, input logic a,
                              input logic cl, input logic ei,
                              input logic [3:0] ed, input logic [3:0] ec,
                              input logic eo);
    vec_t v;
    v.r = r; v.kv = kv; v.code = c; v.ack = a; v.clr = cl;
    v.eIrq = ei; v.eData = ed; v.eCnt = ec; v.eOvf = eo;
    return v;
  endfunction

  initial begin
    //           rst kv code  ack clr  irq data cnt ovf
    vecs[0]  = mk(1, 0, 4'h0, 0, 0,   0, 4'h0, 0, 0);
    vecs[1]  = mk(0, 1, 4'h5, 0, 0,   1, 4'h5, 1, 0);
    vecs[2]  = mk(0, 0, 4'h0, 1, 0,   0, 4'h0, 0, 0);
    vecs[3]  = mk(0, 0, 4'h0, 1, 0,   0, 4'h0, 0, 0);
    vecs[4]  = mk(0, 1, 4'h6, 1, 0,   1, 4'h6, 1, 0);
    vecs[5]  = mk(0, 0, 4'h0, 1, 0,   0, 4'h0, 0, 0);
    vecs[6]  = mk(0, 1, 4'h6, 0, 0,   0, 4'h0, 0, 0);
    vecs[7]  = mk(0, 1, 4'h1, 0, 0,   1, 4'h1, 1, 0);
    vecs[8]  = mk(0, 1, 4'h2, 1, 0,   1, 4'h2, 1, 0);
    vecs[9]  = mk(1, 1, 4'h9, 0, 0,   0, 4'h0, 0, 0);
    vecs[10] = mk(0, 1, 4'hF, 0, 0,   1, 4'hF, 1, 0);
    vecs[11] = mk(1, 0, 4'h0, 0, 0,   0, 4'h0, 0, 0);

    rst = 1'b1; key_valid = 1'b0; key_code = 4'h0;
    irq_ack = 1'b0; overflow_clr = 1'b0;
    @(posedge clk);
    #1;
    idle(1);

    for (int i = 0; i < 12; i++) begin
      cyc(vecs[i].r, vecs[i].kv, vecs[i].code, vecs[i].ack, vecs[i].clr);
      chk4($sformatf("vec%0d", i), vecs[i].eIrq, int'(vecs[i].eData),
           int'(vecs[i].eCnt), vecs[i].eOvf);
    end

    // Fill past capacity, then drain in order.
    cyc(1, 0, 4'h0, 0, 0);
    for (int i = 0; i < 9; i++)
      cyc(0, 1, 4'(i), 0, 0);
    chk4("fill", 1'b1, 0, 8, 1'b1);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("drain%0d.data", i), int'(key_data), i);
      cyc(0, 0, 4'h0, 1, 0);
    end
    chk4("drained", 1'b0, 0, 0, 1'b1);

    // Full queue with push and pop together.
    cyc(1, 0, 4'h0, 0, 0);
    for (int i = 1; i <= 8; i++)
      cyc(0, 1, 4'(i), 0, 0);
    check("full.count", int'(count), 8);
    cyc(0, 1, 4'h7, 1, 0);
    chk4("fullpp", 1'b1, 2, 8, 1'b0);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("ppout%0d", i), int'(key_data),
            (i == 7) ? 7 : i + 2);
      cyc(0, 0, 4'h0, 1, 0);
    end
    chk4("ppdrained", 1'b0, 0, 0, 1'b0);

    // Overflow clear racing an overflow, then clear alone.
    for (int i = 0; i < 9; i++)
      cyc(0, 1, 4'(i), 0, 0);
    check("ovf.set", int'(overflow), 1);
    cyc(0, 1, 4'h9, 0, 1);
    check("ovf.race", int'(overflow), 1);
    check("ovf.race.count", int'(count), 8);
    cyc(0, 0, 4'h0, 0, 1);
    check("ovf.clr", int'(overflow), 0);

    // Repeat filter with HOLDOFF=10.
    cyc(1, 0, 4'h0, 0, 0);
    cyc(0, 1, 4'h3, 0, 0);
    check("rep.t0", int'(count), 1);
    idle(4);
    cyc(0, 1, 4'h3, 0, 0);
    check("rep.t5", int'(count), 1);
    idle(14);
    cyc(0, 1, 4'h3, 0, 0);
    check("rep.t20", int'(count), 2);
    idle(12);
    cyc(0, 1, 4'h3, 0, 0);
    cyc(0, 1, 4'h4, 0, 0);
    chk4("rep.b2b", 1'b1, 3, 4, 1'b0);

    // Reset mid-operation drops everything.
    cyc(1, 0, 4'h0, 0, 0);
    chk4("midrst", 1'b0, 0, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
